regfile_write_ctrl: RTL and testbench

// Sequencer and write-port arbiter for the 32x32 register file. After reset it

---
 rtl/regfile_write_ctrl.sv | 142 ++++++++++++++
 tb/tb_regfile_write_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: write-port sequencer and round-robin arbiter for a
// 32x32 register file.
//   - After reset, clears registers 0..31 through the write port (INIT).
//   - Then grants the port to NREQ write-back requesters round-robin (RUN).
//   - Writes to x0 are accepted but suppressed; reads of x0 return zero.
//   - Supplies write-to-read bypass for the rs/rt read ports.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/rd/data         per-requester write requests (packed by index)
//   req_ready                 one-hot combinational grant
//   rf_write/rf_rd/rf_data    registered register-file write port
//   init_done                 high once the clear sequence has finished
//   rs/rt, *_data_rf          read addresses and raw register-file read data
//   rs_data/rt_data           bypassed, x0-forced read data
module regfile_write_ctrl #(
  parameter int unsigned NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_write,
  output logic [4:0]           rf_rd,
  output logic [31:0]          rf_data,
  output logic                 init_done,
  input  logic [4:0]           rs,
  input  logic [4:0]           rt,
  input  logic [31:0]          rs_data_rf,
  input  logic [31:0]          rt_data_rf,
  output logic [31:0]          rs_data,
  output logic [31:0]          rt_data
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [PTR_W-1:0] rr_ptr;

  logic             grant_any;
  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] cand;
  logic [31:0]      scan_idx;
  logic [PTR_W-1:0] next_ptr;
  logic [4:0]       win_rd;
  logic [31:0]      win_data;

  logic [4:0]       rd_arr   [NREQ];
  logic [31:0]      data_arr [NREQ];

  // Unpack the flat request buses into per-requester arrays.
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign rd_arr[i]   = req_rd[5*i +: 5];
    assign data_arr[i] = req_data[32*i +: 32];
  end

  // Round-robin search from rr_ptr; reset suppresses any grant in its cycle.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    cand      = '0;
    scan_idx  = '0;
    req_ready = '0;
    if (state == S_RUN && !rst) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        scan_idx = (32'(rr_ptr) + k) % NREQ;
        cand     = PTR_W'(scan_idx);
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          winner    = cand;
        end
      end
      if (grant_any) begin
        req_ready[winner] = 1'b1;
      end
    end
  end

  assign win_rd   = rd_arr[winner];
  assign win_data = data_arr[winner];
  assign next_ptr = (winner == LAST_IDX) ? '0 : winner + PTR_W'(1);

  // Sequencer: clear all registers, then serve granted write-backs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      cnt       <= '0;
      rr_ptr    <= '0;
      rf_write  <= 1'b0;
      rf_rd     <= '0;
      rf_data   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          rf_write <= 1'b1;
          rf_rd    <= cnt;
          rf_data  <= '0;
          cnt      <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: begin
          if (grant_any) begin
            // A write to x0 consumes the grant but never reaches the file.
            rf_write <= (win_rd != 5'd0);
            rf_rd    <= win_rd;
            rf_data  <= win_data;
            rr_ptr   <= next_ptr;
          end else begin
            rf_write <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // Read bypass: x0 reads zero, a same-cycle write wins over stale file data.
  always_comb begin
    rs_data = rs_data_rf;
    rt_data = rt_data_rf;
    if (rs == 5'd0) begin
      rs_data = '0;
    end else if (rf_write && rf_rd == rs) begin
      rs_data = rf_data;
    end
    if (rt == 5'd0) begin
      rt_data = '0;
    end else if (rf_write && rf_rd == rt) begin
      rt_data = rf_data;
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Testbench for regfile_write_ctrl (NREQ=3): table-driven arbitration vectors,
// hand-written clear/bypass/reset sequences, and randomized traffic checked
// against a behavioural model.
module tb_regfile_write_ctrl;

  localparam int unsigned NREQ = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_rd;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rf_write;
  logic [4:0]        rf_rd;
  logic [31:0]       rf_data;
  logic              init_done;
  logic [4:0]        rs, rt;
  logic [31:0]       rs_data_rf, rt_data_rf, rs_data, rt_data;

  regfile_write_ctrl #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready),
    .rf_write(rf_write), .rf_rd(rf_rd), .rf_data(rf_data),
    .init_done(init_done),
    .rs(rs), .rt(rt), .rs_data_rf(rs_data_rf), .rt_data_rf(rt_data_rf),
    .rs_data(rs_data), .rt_data(rt_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 32 clear writes with rd 0..31 in order; init_done only on the last one.
  task automatic check_clear();
    for (int i = 0; i < 32; i++) begin
      #1;
      chk("init_ready", 32'(req_ready), 32'd0);
      step();
      chk("init_write", 32'(rf_write), 32'd1);
      chk("init_rd", 32'(rf_rd), 32'(i));
      chk("init_data", rf_data, 32'd0);
      chk("init_done", 32'(init_done), (i == 31) ? 32'd1 : 32'd0);
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] rd;
    logic [95:0] data;
    logic [2:0]  exp_ready;
    logic        exp_write;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[10];

  // Behavioural model state
  int          m_ptr;
  logic        m_write;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [2:0]  pend;
  logic [4:0]  prd  [3];
  logic [31:0] pdat [3];
  int          wait_c [3];

  function automatic int grant_of(input logic [2:0] v, input int ptr);
    for (int k = 0; k < 3; k++) begin
      if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    end
    return -1;
  endfunction

  function automatic logic [31:0] byp(input logic [4:0] a, input logic [31:0] raw);
    if (a == 5'd0) return 32'd0;
    if (m_write && m_rd == a) return m_data;
    return raw;
  endfunction

  localparam logic [31:0] DA = 32'hAAAA_0001;
  localparam logic [31:0] DB = 32'hBBBB_0002;
  localparam logic [31:0] DC = 32'hCCCC_0003;

  initial begin
    logic [14:0] rds_std;
    logic [95:0] dat_std;
    int g;
    logic [2:0] er;
    rds_std = {5'd3, 5'd2, 5'd1};
    dat_std = {DC, DB, DA};
    for (int i = 0; i < 6; i++) begin
      tbl[i].valid     = 3'b111;
      tbl[i].rd        = rds_std;
      tbl[i].data      = dat_std;
      tbl[i].exp_ready = 3'(1 << (i % 3));
      tbl[i].exp_write = 1'b1;
      tbl[i].exp_rd    = 5'((i % 3) + 1);
      tbl[i].exp_data  = (i % 3 == 0) ? DA : (i % 3 == 1) ? DB : DC;
    end
    tbl[6] = '{3'b010, {5'd3, 5'd5, 5'd1}, {DC, 32'hDEAD_BEEF, DA}, 3'b010, 1'b1, 5'd5, 32'hDEAD_BEEF};
    tbl[7] = '{3'b001, {5'd3, 5'd5, 5'd0}, {DC, 32'hDEAD_BEEF, 32'h1234}, 3'b001, 1'b0, 5'd0, 32'd0};
    tbl[8] = '{3'b000, rds_std, dat_std, 3'b000, 1'b0, 5'd0, 32'd0};
    tbl[9] = '{3'b101, rds_std, dat_std, 3'b100, 1'b1, 5'd3, DC};

    // Reset held two cycles with requests present.
    rst = 1'b1; req_valid = 3'b111; req_rd = rds_std; req_data = dat_std;
    rs = 5'd0; rt = 5'd0; rs_data_rf = 32'hFFFF_FFFF; rt_data_rf = 32'hFFFF_FFFF;
    step(); step();
    chk("rst_write", 32'(rf_write), 32'd0);
    chk("rst_rd", 32'(rf_rd), 32'd0);
    chk("rst_data", rf_data, 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    check_clear();

    // Arbitration vectors; rs=0 must read zero despite all-ones file data.
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].valid; req_rd = tbl[i].rd; req_data = tbl[i].data;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("vec%0d_rs0", i), rs_data, 32'd0);
      step();
      chk($sformatf("vec%0d_write", i), 32'(rf_write), 32'(tbl[i].exp_write));
      if (tbl[i].exp_write) begin
        chk($sformatf("vec%0d_rd", i), 32'(rf_rd), 32'(tbl[i].exp_rd));
        chk($sformatf("vec%0d_data", i), rf_data, tbl[i].exp_data);
      end
    end

    // Bypass: write of 0x55 to r7 visible on rs/rt the cycle it is on the port.
    req_valid = 3'b010; req_rd = {5'd3, 5'd7, 5'd1}; req_data = {DC, 32'h55, DA};
    #1;
    chk("byp_ready", 32'(req_ready), 32'b010);
    step();
    req_valid = 3'b000;
    rs = 5'd7; rs_data_rf = 32'h11; rt = 5'd8; rt_data_rf = 32'h22;
    #1;
    chk("byp_rs_hit", rs_data, 32'h55);
    chk("byp_rt_miss", rt_data, 32'h22);
    rt = 5'd7;
    #1;
    chk("byp_rt_hit", rt_data, 32'h55);

    // Randomized traffic against the model; requests held until accepted.
    m_ptr = 2; m_write = 1'b1; m_rd = 5'd7; m_data = 32'h55;
    pend = 3'b000;
    for (int r = 0; r < 3; r++) begin
      prd[r] = 5'd0; pdat[r] = 32'd0; wait_c[r] = 0;
    end
    for (int c = 0; c < 300; c++) begin
      for (int r = 0; r < 3; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r] = 1'b1;
          prd[r] = 5'($urandom_range(0, 31));
          pdat[r] = $urandom;
          wait_c[r] = 0;
        end
      end
      req_valid = pend;
      req_rd = {prd[2], prd[1], prd[0]};
      req_data = {pdat[2], pdat[1], pdat[0]};
      case ($urandom_range(0, 2))
        0: rs = 5'd0;
        1: rs = m_rd;
        default: rs = 5'($urandom_range(0, 31));
      endcase
      rt = ($urandom_range(0, 1) == 0) ? m_rd : 5'($urandom_range(0, 31));
      rs_data_rf = $urandom; rt_data_rf = $urandom;
      #1;
      g = grant_of(pend, m_ptr);
      er = (g >= 0) ? 3'(1 << g) : 3'b000;
      chk("rnd_ready", 32'(req_ready), 32'(er));
      chk("rnd_rs", rs_data, byp(rs, rs_data_rf));
      chk("rnd_rt", rt_data, byp(rt, rt_data_rf));
      step();
      if (g >= 0) begin
        chk("rnd_starve", (wait_c[g] <= 2) ? 32'd1 : 32'd0, 32'd1);
        m_write = (prd[g] != 5'd0);
        m_rd = prd[g];
        m_data = pdat[g];
        m_ptr = (g + 1) % 3;
        pend[g] = 1'b0;
      end else begin
        m_write = 1'b0;
      end
      for (int r = 0; r < 3; r++) begin
        if (pend[r]) wait_c[r]++;
      end
      chk("rnd_write", 32'(rf_write), 32'(m_write));
      if (m_write) begin
        chk("rnd_rd", 32'(rf_rd), 32'(m_rd));
        chk("rnd_data", rf_data, m_data);
      end
    end

    // Reset mid-RUN with all requesters valid: no grant, clear restarts.
    rst = 1'b1; req_valid = 3'b111; req_rd = rds_std; req_data = dat_std;
    #1;
    chk("rrst_ready", 32'(req_ready), 32'd0);
    step();
    chk("rrst_write", 32'(rf_write), 32'd0);
    chk("rrst_done", 32'(init_done), 32'd0);
    rst = 1'b0;
    check_clear();
    #1;
    chk("post_rrst_ready", 32'(req_ready), 32'b001);
    step();
    chk("post_rrst_write", 32'(rf_write), 32'd1);
    chk("post_rrst_rd", 32'(rf_rd), 32'd1);
    chk("post_rrst_data", rf_data, DA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
